// File: rtl/rail_seq_n.sv
// N-rail power sequencer: ascending power-up, descending power-down,
// each step gated by that rail's synchronised power-good.
// Ports:
//   clk, rst        clock, async active-high reset
//   pwr_main        1 = power up, 0 = power down
//   go_out_flt      fault release request
//   rail_pwrgd      raw per-rail power-good (async)
//   rail_en         registered rail enables
//   pwr_gd          all rails up (ST_DONE)
//   pwr_flt         FSM in ST_FAULT
//   flt_code        0 none, 1 pwrgd lost, 2 on-timeout, 3 off-timeout
//   flt_rail        offending rail bitmask, latched on fault entry
//   fsm_state       debug state encoding
module rail_seq_n #(
  parameter int NUM_RAILS   = 4,
  parameter int CNT_W       = 16,
  parameter int PG_TIMEOUT  = 1000,
  parameter int OFF_TIMEOUT = 1000,
  parameter int STAGE_DLY   = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pwr_main,
  input  logic                 go_out_flt,
  input  logic [NUM_RAILS-1:0] rail_pwrgd,
  output logic [NUM_RAILS-1:0] rail_en,
  output logic                 pwr_gd,
  output logic                 pwr_flt,
  output logic [1:0]           flt_code,
  output logic [NUM_RAILS-1:0] flt_rail,
  output logic [2:0]           fsm_state
);

  localparam int IDX_W = $clog2(NUM_RAILS);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_RAILS - 1);
  localparam logic [CNT_W-1:0] T_ON = CNT_W'(PG_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] T_OFF = CNT_W'(OFF_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] T_DLY = CNT_W'(STAGE_DLY - 1);

  typedef enum logic [2:0] {
    ST_FAULT    = 3'd0,
    ST_OFF      = 3'd1,
    ST_ON_WAIT  = 3'd2,
    ST_ON_DLY   = 3'd3,
    ST_DONE     = 3'd4,
    ST_OFF_WAIT = 3'd5
  } state_t;

  state_t               r_state, w_state;
  logic [IDX_W-1:0]     r_idx, w_idx;
  logic [CNT_W-1:0]     r_tmr, w_tmr;
  logic [NUM_RAILS-1:0] r_pg_m, r_pg_s, r_pg_d;
  logic [NUM_RAILS-1:0] r_en, w_en;
  logic [1:0]           r_code, w_code;
  logic [NUM_RAILS-1:0] r_frail, w_frail;

  logic [NUM_RAILS-1:0] w_lost, w_bit;
  logic                 w_pg, w_active, w_up;
  logic                 w_on_to, w_off_to;

  always_comb begin
    w_lost   = r_en & r_pg_d & ~r_pg_s;
    w_bit    = NUM_RAILS'(1) << r_idx;
    w_pg     = r_pg_s[r_idx];
    w_up     = (r_state == ST_ON_WAIT) ||
               (r_state == ST_ON_DLY)  ||
               (r_state == ST_DONE);
    w_active = w_up || (r_state == ST_OFF_WAIT);
    w_on_to  = (r_state == ST_ON_WAIT) && !w_pg &&
               (r_tmr >= T_ON);
    w_off_to = (r_state == ST_OFF_WAIT) && w_pg &&
               (r_tmr >= T_OFF);

    w_state = r_state;
    w_idx   = r_idx;
    w_en    = r_en;
    w_code  = r_code;
    w_frail = r_frail;

    if (w_active && (|w_lost || w_on_to || w_off_to)) begin
      // Abrupt shutdown: every enable drops at once.
      w_state = ST_FAULT;
      w_idx   = '0;
      w_en    = '0;
      w_code  = (|w_lost) ? 2'd1 : (w_on_to ? 2'd2 : 2'd3);
      w_frail = w_lost |
                ((w_on_to || w_off_to) ? w_bit : '0);
    end else if (w_up && !pwr_main) begin
      // idx already names the highest enabled rail.
      w_state = ST_OFF_WAIT;
      w_en    = r_en & ~w_bit;
    end else begin
      unique case (r_state)
        ST_OFF: begin
          if (pwr_main) begin
            w_state = ST_ON_WAIT;
            w_idx   = '0;
            w_en    = NUM_RAILS'(1);
          end
        end
        ST_ON_WAIT: begin
          if (w_pg) begin
            w_state = (r_idx == LAST) ? ST_DONE : ST_ON_DLY;
          end
        end
        ST_ON_DLY: begin
          if (r_tmr >= T_DLY) begin
            w_state = ST_ON_WAIT;
            w_idx   = r_idx + IDX_W'(1);
            w_en    = r_en | (w_bit << 1);
          end
        end
        ST_DONE: begin
        end
        ST_OFF_WAIT: begin
          if (!w_pg) begin
            if (r_idx == '0) begin
              w_state = ST_OFF;
            end else begin
              w_idx = r_idx - IDX_W'(1);
              w_en  = r_en & ~(w_bit >> 1);
            end
          end
        end
        ST_FAULT: begin
          if (go_out_flt && !(|r_pg_s)) begin
            w_state = ST_OFF;
            w_code  = 2'd0;
            w_frail = '0;
          end
        end
        default: begin
          w_state = ST_OFF;
        end
      endcase
    end

    if ((w_state != r_state) || (w_idx != r_idx)) begin
      w_tmr = '0;
    end else if (r_tmr != '1) begin
      w_tmr = r_tmr + CNT_W'(1);
    end else begin
      w_tmr = r_tmr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_OFF;
      r_idx   <= '0;
      r_tmr   <= '0;
      r_pg_m  <= '0;
      r_pg_s  <= '0;
      r_pg_d  <= '0;
      r_en    <= '0;
      r_code  <= '0;
      r_frail <= '0;
    end else begin
      r_state <= w_state;
      r_idx   <= w_idx;
      r_tmr   <= w_tmr;
      r_pg_m  <= rail_pwrgd;
      r_pg_s  <= r_pg_m;
      r_pg_d  <= r_pg_s;
      r_en    <= w_en;
      r_code  <= w_code;
      r_frail <= w_frail;
    end
  end

  assign rail_en   = r_en;
  assign pwr_gd    = (r_state == ST_DONE);
  assign pwr_flt   = (r_state == ST_FAULT);
  assign flt_code  = r_code;
  assign flt_rail  = r_frail;
  assign fsm_state = r_state;

endmodule

// File: tb/tb_rail_seq_n.sv
// Directed bench for rail_seq_n with 3 rails and a
// behavioural rail model driving power-good.
module tb_rail_seq_n;
  localparam int N = 3;
  localparam int ON_D = 3;
  localparam int OFF_D = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         pwr_main = 1'b0;
  logic         go_out_flt = 1'b0;
  logic [N-1:0] rail_pwrgd;
  logic [N-1:0] rail_en;
  logic         pwr_gd;
  logic         pwr_flt;
  logic [1:0]   flt_code;
  logic [N-1:0] flt_rail;
  logic [2:0]   fsm_state;

  logic [N-1:0] mpg = '0;
  logic [N-1:0] stuck_lo = '0;
  logic [N-1:0] stuck_hi = '0;
  logic [N-1:0] force_low = '0;
  int           cnt [N];
  int           en1_cyc = 0;
  int           en1_ref;
  int           vectors = 0;
  int           miscompares = 0;
  int           n;

  assign rail_pwrgd = mpg & ~force_low;

  always #5 clk = ~clk;

  rail_seq_n #(
    .NUM_RAILS  (N),
    .CNT_W      (16),
    .PG_TIMEOUT (8),
    .OFF_TIMEOUT(8),
    .STAGE_DLY  (4)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .pwr_main  (pwr_main),
    .go_out_flt(go_out_flt),
    .rail_pwrgd(rail_pwrgd),
    .rail_en   (rail_en),
    .pwr_gd    (pwr_gd),
    .pwr_flt   (pwr_flt),
    .flt_code  (flt_code),
    .flt_rail  (flt_rail),
    .fsm_state (fsm_state)
  );

  // Rail model: pwrgd follows enable after ON_D/OFF_D cycles.
  always @(negedge clk) begin
    if (rail_en[1]) en1_cyc++;
    for (int i = 0; i < N; i++) begin
      if (rail_en[i] && !stuck_lo[i] && !mpg[i]) begin
        cnt[i]++;
        if (cnt[i] >= ON_D) begin
          mpg[i] = 1'b1;
          cnt[i] = 0;
        end
      end else if (!rail_en[i] && !stuck_hi[i] && mpg[i]) begin
        cnt[i]++;
        if (cnt[i] >= OFF_D) begin
          mpg[i] = 1'b0;
          cnt[i] = 0;
        end
      end else begin
        cnt[i] = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] sel(input int w);
    case (w)
      0:       return rail_en;
      1:       return fsm_state;
      default: return {2'b00, pwr_gd};
    endcase
  endfunction

  // Steps until the selected signal equals v, bounded by max.
  task automatic waitv(input int w, input logic [2:0] v,
                       input int max, output int cyc);
    cyc = 0;
    while (sel(w) !== v && cyc < max) begin
      step();
      cyc++;
    end
  endtask

  initial begin
    step();
    step();
    rst = 1'b0;
    step();
    chk("rst_state", 32'(fsm_state), 1);
    chk("rst_en", 32'(rail_en), 0);
    chk("rst_gd_flt", {pwr_gd, pwr_flt}, 0);
    chk("rst_code", {flt_code, flt_rail}, 0);

    // 1: ordered power-up
    pwr_main = 1'b1;
    step();
    chk("up_en0", 32'(rail_en), 3'b001);
    chk("up_st", 32'(fsm_state), 2);
    waitv(0, 3'b011, 30, n);
    chk("up_gap1", n, 9);
    waitv(0, 3'b111, 30, n);
    chk("up_gap2", n, 9);
    waitv(2, 3'b001, 30, n);
    chk("up_gd_lat", n, 5);
    chk("up_done", 32'(fsm_state), 4);

    // 2: ordered power-down
    pwr_main = 1'b0;
    step();
    chk("dn_first", {fsm_state, pwr_gd, rail_en}, {3'd5, 1'b0, 3'b011});
    waitv(0, 3'b001, 30, n);
    chk("dn_gap1", n, 4);
    waitv(0, 3'b000, 30, n);
    chk("dn_gap2", n, 4);
    waitv(1, 3'd1, 30, n);
    chk("dn_off", n, 4);

    // 3: rail 1 never good -> on-timeout
    stuck_lo = 3'b010;
    pwr_main = 1'b1;
    step();
    waitv(0, 3'b011, 30, n);
    chk("to_en1", n, 9);
    waitv(1, 3'd0, 30, n);
    chk("to_lat", n, 8);
    chk("to_status", {rail_en, flt_code, flt_rail, pwr_flt},
        {3'b000, 2'd2, 3'b010, 1'b1});
    pwr_main = 1'b0;
    go_out_flt = 1'b1;
    step();
    chk("to_hold", 32'(fsm_state), 0);
    waitv(1, 3'd1, 30, n);
    chk("to_exit", n, 3);
    chk("to_clr", {flt_code, flt_rail, pwr_flt}, 0);
    go_out_flt = 1'b0;
    stuck_lo = '0;

    // 4: pwrgd glitch on rail 0 while DONE
    pwr_main = 1'b1;
    waitv(2, 3'b001, 60, n);
    chk("gl_done", 32'(pwr_gd), 1);
    force_low = 3'b001;
    waitv(1, 3'd0, 30, n);
    chk("gl_lat", n, 3);
    chk("gl_status", {rail_en, flt_code, flt_rail, pwr_flt},
        {3'b000, 2'd1, 3'b001, 1'b1});
    force_low = '0;
    pwr_main = 1'b0;
    go_out_flt = 1'b1;
    waitv(1, 3'd1, 30, n);
    chk("gl_off", 32'(fsm_state), 1);
    chk("gl_clr", {flt_code, flt_rail, pwr_flt}, 0);
    go_out_flt = 1'b0;
    repeat (6) step();

    // 5: abort during ON_DLY of rail 0
    en1_ref = en1_cyc;
    pwr_main = 1'b1;
    step();
    waitv(1, 3'd3, 30, n);
    chk("ab_dly", n, 5);
    pwr_main = 1'b0;
    step();
    chk("ab_first", {fsm_state, rail_en}, {3'd5, 3'b000});
    waitv(1, 3'd1, 30, n);
    chk("ab_off", n, 4);
    chk("ab_no_en1", en1_cyc - en1_ref, 0);
    repeat (4) step();

    // 6: async reset while fully up
    pwr_main = 1'b1;
    waitv(0, 3'b111, 60, n);
    chk("rs_up", 32'(rail_en), 3'b111);
    #2;
    rst = 1'b1;
    #1;
    chk("rs_async", {rail_en, pwr_gd, pwr_flt, flt_code, flt_rail},
        0);
    chk("rs_state", 32'(fsm_state), 1);
    pwr_main = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
    chk("rs_after", {fsm_state, rail_en}, {3'd1, 3'b000});
    repeat (6) step();

    // 7: rail 2 never drops -> off-timeout
    pwr_main = 1'b1;
    waitv(2, 3'b001, 60, n);
    chk("ot_done", 32'(pwr_gd), 1);
    stuck_hi = 3'b100;
    pwr_main = 1'b0;
    step();
    chk("ot_first", 32'(rail_en), 3'b011);
    waitv(1, 3'd0, 30, n);
    chk("ot_lat", n, 8);
    chk("ot_status", {rail_en, flt_code, flt_rail},
        {3'b000, 2'd3, 3'b100});
    go_out_flt = 1'b1;
    repeat (6) step();
    chk("ot_stuck", 32'(fsm_state), 0);
    stuck_hi = '0;
    waitv(1, 3'd1, 30, n);
    chk("ot_exit", {fsm_state, flt_code, pwr_flt}, {3'd1, 2'd0, 1'b0});
    go_out_flt = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
